// File: rtl/mont_red_sos_256b_pkg.sv
// Shared constants and FSM encoding for the word-serial SM2 Montgomery reducer.
package mont_red_sos_256b_pkg;

  localparam int WORD_W   = 64;
  localparam int WORD_CNT = 4;

  localparam logic [WORD_CNT*WORD_W-1:0] SM2_P =
    256'hFFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF;
  localparam logic [WORD_W-1:0] SM2_N0_INV = 64'h1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MQ,
    ST_MAC,
    ST_PROP,
    ST_SUB
  } state_t;

endpackage

// File: rtl/mont_red_sos_256b_if.sv
// Start/operand/result bundle between the SOS multiplier side and the reducer.
interface mont_red_sos_256b_if;

  logic         red_vld_i;
  logic [511:0] red_t_i;
  logic         red_busy_o;
  logic         red_fin_o;
  logic [255:0] red_r_o;

  modport master (
    output red_vld_i,
    output red_t_i,
    input  red_busy_o,
    input  red_fin_o,
    input  red_r_o
  );

  modport slave (
    input  red_vld_i,
    input  red_t_i,
    output red_busy_o,
    output red_fin_o,
    output red_r_o
  );

endinterface

// File: rtl/mul_64b_wrapper.sv
// Combinational 64x64 unsigned multiplier shared by the reduction datapath.
module mul_64b_wrapper (
  input  logic [63:0]  a,
  input  logic [63:0]  b,
  output logic [127:0] prod
);

  assign prod = a * b;

endmodule

// File: rtl/mont_red_sos_256b.sv
// Word-serial Montgomery reduction: R = T * 2^-256 mod P using one shared
// 64x64 multiplier, four MQ/MAC/PROP iterations and a final conditional subtract.
module mont_red_sos_256b
  import mont_red_sos_256b_pkg::*;
#(
  parameter logic [255:0] P      = SM2_P,
  parameter logic [63:0]  N0_INV = SM2_N0_INV
) (
  input  logic                clk,
  input  logic                rst,
  mont_red_sos_256b_if.slave  bus
);

  localparam logic [WORD_CNT-1:0][WORD_W-1:0] P_WORDS = P;

  state_t                          state_reg, state_next;
  logic [1:0]                      i_reg, i_next;
  logic [1:0]                      j_reg, j_next;
  logic [8:0][WORD_W-1:0]          t_reg, t_next;
  logic [WORD_W:0]                 c_reg, c_next;
  logic [WORD_W-1:0]               m_reg, m_next;
  logic                            vld_r1;
  logic                            busy_reg, busy_next;
  logic                            fin_reg, fin_next;
  logic [255:0]                    r_reg, r_next;

  logic [WORD_W-1:0]               mul_a, mul_b;
  logic [2*WORD_W-1:0]             prod;
  logic                            start;
  logic [3:0]                      mac_idx;
  logic [2*WORD_W:0]               mac_sum;
  logic [8:0]                      prop_sh;
  logic [9*WORD_W-1:0]             prop_add;
  logic [256:0]                    u;
  logic [255:0]                    u_diff;

  mul_64b_wrapper u_mul (
    .a    (mul_a),
    .b    (mul_b),
    .prod (prod)
  );

  assign start = bus.red_vld_i & ~vld_r1 & (state_reg == ST_IDLE);

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_reg)
      ST_MQ: begin
        mul_a = t_reg[i_reg];
        mul_b = N0_INV;
      end
      ST_MAC: begin
        mul_a = m_reg;
        mul_b = P_WORDS[j_reg];
      end
      default: ;
    endcase
  end

  assign mac_idx  = {2'b00, i_reg} + {2'b00, j_reg};
  assign mac_sum  = {1'b0, prod} + {65'b0, t_reg[mac_idx]} + {64'b0, c_reg};
  // Carry lands at word i+4 and ripples up through T[8]; overflow past T[8] is dropped.
  assign prop_sh  = {({1'b0, i_reg} + 3'd4), 6'b000000};
  assign prop_add = {511'b0, c_reg} << prop_sh;
  assign u        = {t_reg[8][0], t_reg[7], t_reg[6], t_reg[5], t_reg[4]};
  // U < 2P, so a 256-bit wrap-around difference is exact whenever U >= P.
  assign u_diff   = u[255:0] - P;

  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    t_next     = t_reg;
    c_next     = c_reg;
    m_next     = m_reg;
    busy_next  = busy_reg;
    fin_next   = 1'b0;
    r_next     = r_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          t_next     = {64'b0, bus.red_t_i};
          i_next     = 2'd0;
          j_next     = 2'd0;
          busy_next  = 1'b1;
          state_next = ST_MQ;
        end
      end
      ST_MQ: begin
        m_next     = prod[WORD_W-1:0];
        c_next     = '0;
        state_next = ST_MAC;
      end
      ST_MAC: begin
        {c_next, t_next[mac_idx]} = mac_sum;
        j_next = j_reg + 2'd1;
        if (j_reg == 2'd3) state_next = ST_PROP;
      end
      ST_PROP: begin
        t_next = t_reg + prop_add;
        i_next = i_reg + 2'd1;
        state_next = (i_reg == 2'd3) ? ST_SUB : ST_MQ;
      end
      ST_SUB: begin
        r_next     = (u >= {1'b0, P}) ? u_diff : u[255:0];
        fin_next   = 1'b1;
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      i_reg     <= '0;
      j_reg     <= '0;
      t_reg     <= '0;
      c_reg     <= '0;
      m_reg     <= '0;
      vld_r1    <= 1'b0;
      busy_reg  <= 1'b0;
      fin_reg   <= 1'b0;
      r_reg     <= '0;
    end else begin
      state_reg <= state_next;
      i_reg     <= i_next;
      j_reg     <= j_next;
      t_reg     <= t_next;
      c_reg     <= c_next;
      m_reg     <= m_next;
      vld_r1    <= bus.red_vld_i;
      busy_reg  <= busy_next;
      fin_reg   <= fin_next;
      r_reg     <= r_next;
    end
  end

  assign bus.red_busy_o = busy_reg;
  assign bus.red_fin_o  = fin_reg;
  assign bus.red_r_o    = r_reg;

endmodule

// File: tb/tb_mont_red_sos_256b.sv
// Scoreboard bench for mont_red_sos_256b: expected residues and done cycles are
// queued at stimulus time and checked by an independent monitor on each done pulse.
module tb_mont_red_sos_256b;
  import mont_red_sos_256b_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic [255:0] r;
    int           cyc;
  } exp_t;
  exp_t sb[$];

  mont_red_sos_256b_if bus ();

  mont_red_sos_256b dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  // Golden model: reduce mod P, then halve modulo P 256 times.
  function automatic logic [255:0] ref_red(input logic [511:0] t);
    logic [511:0] rem;
    logic [256:0] x;
    rem = t % {256'b0, SM2_P};
    x   = {1'b0, rem[255:0]};
    for (int k = 0; k < 256; k++) begin
      if (x[0]) x = x + {1'b0, SM2_P};
      x = x >> 1;
    end
    return x[255:0];
  endfunction

  function automatic logic [511:0] rand_t();
    logic [255:0] hi;
    logic [255:0] lo;
    for (int k = 0; k < 8; k++) begin
      hi[k*32 +: 32] = $urandom();
      lo[k*32 +: 32] = $urandom();
    end
    if (hi >= SM2_P) hi = hi - SM2_P;
    return {hi, lo};
  endfunction

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  // Drives a one-cycle rising edge; an accepted start finishes 26 cycles later.
  task automatic pulse(input logic [511:0] t, input bit accept);
    @(posedge clk); #1;
    bus.red_t_i   = t;
    bus.red_vld_i = 1'b1;
    if (accept) sb.push_back('{ref_red(t), cyc + 26});
    $display("issue t=%h accept=%0d cyc=%0d", t, accept, cyc);
    @(posedge clk); #1;
    bus.red_vld_i = 1'b0;
    bus.red_t_i   = rand_t();
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200 && sb.size() != 0; n++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.red_fin_o) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fin: done pulse at cyc=%0d r=%h, required none", cyc, bus.red_r_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checks += 2;
          if (bus.red_r_o !== e.r) begin
            errors++;
            $display("FAIL result: got %h required %h", bus.red_r_o, e.r);
          end else begin
            $display("ok   result %h at cyc=%0d", bus.red_r_o, cyc);
          end
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL latency: fin at cyc %0d required cyc %0d", cyc, e.cyc);
          end
        end
      end
      if (dut.state_reg == ST_PROP) begin
        checks++;
        if (dut.t_reg[dut.i_reg] !== 64'd0) begin
          errors++;
          $display("FAIL low_word_zero: T[%0d]=%h after MAC, required 0", dut.i_reg, dut.t_reg[dut.i_reg]);
        end
      end
    end
  end

  initial begin
    logic [511:0] v;
    logic [511:0] t1;
    logic [511:0] t2;
    int           k2;

    bus.red_vld_i = 1'b0;
    bus.red_t_i   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_r",    bus.red_r_o, 256'd0);
    check("reset_fin",  {255'd0, bus.red_fin_o}, 256'd0);
    check("reset_busy", {255'd0, bus.red_busy_o}, 256'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // T = 0 with busy window checks.
    pulse(512'd0, 1'b1);
    check("busy_e1", {255'd0, bus.red_busy_o}, 256'd1);
    repeat (24) @(posedge clk);
    #1;
    check("busy_e25", {255'd0, bus.red_busy_o}, 256'd1);
    @(posedge clk); #1;
    check("busy_e26", {255'd0, bus.red_busy_o}, 256'd0);
    wait_drain();

    v = {256'd1, 256'd0};             pulse(v, 1'b1); wait_drain();
    v = {256'd5, 256'd0};             pulse(v, 1'b1); wait_drain();
    v = {SM2_P - 256'd1, 256'd0};     pulse(v, 1'b1); wait_drain();
    v = {256'd0, SM2_P};              pulse(v, 1'b1); wait_drain();

    // Held-high start, then a new edge with a dropped edge at E+10.
    t1 = rand_t();
    t2 = rand_t();
    @(posedge clk); #1;
    bus.red_t_i   = t1;
    bus.red_vld_i = 1'b1;
    sb.push_back('{ref_red(t1), cyc + 26});
    $display("issue t=%h held cyc=%0d", t1, cyc);
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      bus.red_t_i = rand_t();
    end
    bus.red_vld_i = 1'b0;
    k2 = cyc + 1;
    pulse(t2, 1'b1);
    repeat (k2 + 10 - cyc) @(posedge clk);
    #1;
    bus.red_t_i   = rand_t();
    bus.red_vld_i = 1'b1;
    $display("issue ignored edge cyc=%0d", cyc);
    @(posedge clk); #1;
    bus.red_vld_i = 1'b0;
    wait_drain();
    repeat (30) @(posedge clk);

    // Abort by reset at E+10..E+12.
    pulse(rand_t(), 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check("abort_r",    bus.red_r_o, 256'd0);
    check("abort_busy", {255'd0, bus.red_busy_o}, 256'd0);
    repeat (40) @(posedge clk);
    v = {256'd1, 256'd0};
    pulse(v, 1'b1);
    wait_drain();

    for (int n = 0; n < 4; n++) begin
      pulse(rand_t(), 1'b1);
      wait_drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
